// File: rtl/riscv_constants.sv
// rtl/riscv_constants.sv - shared RV32 enums: operand-1 select and control-sequencer state
package riscv_constants;

  // Operand-1 mux select: register rs1, program counter, or constant zero
  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } OP1_SEL;

  // Multi-cycle control sequencer states
  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } CTRL_STATE;

endpackage

// File: rtl/riscv_seq_ctrl.sv
// rtl/riscv_seq_ctrl.sv - multi-cycle fetch/decode/execute/memory/writeback sequencer with retire counter
module riscv_seq_ctrl
  import riscv_constants::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   halt,
  output logic                   imem_req,
  input  logic                   imem_ack,
  output logic                   dmem_req,
  output logic                   dmem_we,
  input  logic                   dmem_ack,
  input  OP1_SEL                 dec_op1_sel,
  input  logic                   dec_mem_rd,
  input  logic                   dec_mem_wr,
  input  logic                   dec_wb_en,
  input  logic                   dec_illegal,
  output OP1_SEL                 op1_sel,
  output logic                   ir_we,
  output logic                   pc_we,
  output logic                   alu_we,
  output logic                   rf_we,
  output logic                   trap,
  output logic [WORD_LENGTH-1:0] retire_cnt,
  output CTRL_STATE              state
);

  // Asserted in the cycle an instruction completes; the counter bumps on the following edge
  logic retire;

  // Strobes and operand select decoded from the current state and handshake inputs
  always_comb begin
    op1_sel  = OP1_PC;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    alu_we   = 1'b0;
    rf_we    = 1'b0;
    trap     = 1'b0;
    retire   = 1'b0;
    case (state)
      ST_FETCH: begin
        // ALU computes PC+4 here, so PC and IR load together on the ack
        imem_req = !halt;
        if (!halt && imem_ack) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      ST_DECODE: begin
        op1_sel = OP1_RS1;
      end
      ST_EXEC: begin
        op1_sel = dec_op1_sel;
        alu_we  = 1'b1;
      end
      ST_MEM: begin
        // A store wins when the decoder flags both load and store
        op1_sel  = OP1_RS1;
        dmem_req = 1'b1;
        dmem_we  = dec_mem_wr;
        retire   = dmem_ack && dec_mem_wr;
      end
      ST_WB: begin
        op1_sel = OP1_RS1;
        rf_we   = dec_wb_en;
        retire  = 1'b1;
      end
      ST_TRAP: begin
        trap = 1'b1;
      end
      default: begin
        op1_sel = OP1_PC;
      end
    endcase
  end

  // State register and transitions; reset forces RST even mid-instruction
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_RST;
    end else begin
      case (state)
        ST_RST:    state <= ST_FETCH;
        ST_FETCH:  if (ir_we) state <= ST_DECODE;
        ST_DECODE: state <= dec_illegal ? ST_TRAP : ST_EXEC;
        ST_EXEC:   state <= (dec_mem_rd || dec_mem_wr) ? ST_MEM : ST_WB;
        ST_MEM:    if (dmem_ack) state <= dec_mem_wr ? ST_FETCH : ST_WB;
        ST_WB:     state <= ST_FETCH;
        ST_TRAP:   state <= ST_FETCH;
        default:   state <= ST_RST;
      endcase
    end
  end

  // Retired-instruction counter; wraps naturally at full width, traps never count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_cnt <= '0;
    end else if (retire) begin
      retire_cnt <= retire_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// tb/tb_riscv_seq_ctrl.sv - scoreboard bench for riscv_seq_ctrl with directed per-cycle vectors
module tb_riscv_seq_ctrl;
  import riscv_constants::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        halt = 1'b0;
  logic        imem_ack = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        dec_mem_rd = 1'b0;
  logic        dec_mem_wr = 1'b0;
  logic        dec_wb_en = 1'b0;
  logic        dec_illegal = 1'b0;
  OP1_SEL      dec_op1_sel = OP1_RS1;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_we, rf_we, trap;
  OP1_SEL      op1_sel;
  logic [31:0] retire_cnt;
  CTRL_STATE   state;

  riscv_seq_ctrl #(.WORD_LENGTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .dec_op1_sel(dec_op1_sel), .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr),
    .dec_wb_en(dec_wb_en), .dec_illegal(dec_illegal),
    .op1_sel(op1_sel), .ir_we(ir_we), .pc_we(pc_we), .alu_we(alu_we),
    .rf_we(rf_we), .trap(trap), .retire_cnt(retire_cnt), .state(state)
  );

  always #5 clk = ~clk;

  // Strobe order: {imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_we, rf_we, trap}
  localparam logic [7:0] K_NONE  = 8'b0000_0000;
  localparam logic [7:0] K_IREQ  = 8'b1000_0000;
  localparam logic [7:0] K_FETCH = 8'b1001_1000;
  localparam logic [7:0] K_DRD   = 8'b0100_0000;
  localparam logic [7:0] K_DWR   = 8'b0110_0000;
  localparam logic [7:0] K_ALU   = 8'b0000_0100;
  localparam logic [7:0] K_RF    = 8'b0000_0010;
  localparam logic [7:0] K_TRAP  = 8'b0000_0001;

  typedef struct {
    int          id;
    logic [44:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [44:0] obs;
  int          compared = 0;
  int          mismatched = 0;
  int          cyc_id = 0;
  bit          do_force = 1'b0;

  // Drive one cycle of inputs after the edge and queue the outputs expected in that cycle
  task automatic cyc(input logic rn, input logic h, input logic ia, input logic da,
                     input CTRL_STATE es, input OP1_SEL eo, input logic [7:0] ek,
                     input logic [31:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n    = rn;
    halt     = h;
    imem_ack = ia;
    dmem_ack = da;
    if (do_force) begin
      force dut.retire_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.retire_cnt;
      do_force = 1'b0;
    end
    e.id = cyc_id;
    e.v  = {es, eo, ek, ec};
    exp_q.push_back(e);
    cyc_id++;
  endtask

  task automatic set_dec(input OP1_SEL op, input logic rd, input logic wr,
                         input logic wb, input logic ill);
    dec_op1_sel = op;
    dec_mem_rd  = rd;
    dec_mem_wr  = wr;
    dec_wb_en   = wb;
    dec_illegal = ill;
  endtask

  // Monitor: compare whatever the DUT presents mid-cycle against the oldest queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      obs = {state, op1_sel, imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_we, rf_we, trap, retire_cnt};
      compared++;
      if (obs !== mon_e.v) begin
        mismatched++;
        $display("FAIL cycle%0d: got state=%0d op1=%0d strb=%b cnt=%h, expected state=%0d op1=%0d strb=%b cnt=%h",
                 mon_e.id, obs[44:42], obs[41:40], obs[39:32], obs[31:0],
                 mon_e.v[44:42], mon_e.v[41:40], mon_e.v[39:32], mon_e.v[31:0]);
      end
    end
  end

  initial begin
    // Reset held, then released
    cyc(0, 0, 0, 0, ST_RST, OP1_PC, K_NONE, 32'd0);
    cyc(0, 0, 0, 0, ST_RST, OP1_PC, K_NONE, 32'd0);
    set_dec(OP1_ZERO, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, ST_RST, OP1_PC, K_NONE, 32'd0);

    // ALU instruction, zero-wait fetch
    cyc(1, 0, 1, 0, ST_FETCH,  OP1_PC,   K_FETCH, 32'd0);
    cyc(1, 0, 0, 0, ST_DECODE, OP1_RS1,  K_NONE,  32'd0);
    cyc(1, 0, 0, 0, ST_EXEC,   OP1_ZERO, K_ALU,   32'd0);
    cyc(1, 0, 0, 0, ST_WB,     OP1_RS1,  K_RF,    32'd0);

    // Load with dmem_ack delayed 3 cycles
    cyc(1, 0, 1, 0, ST_FETCH,  OP1_PC,  K_FETCH, 32'd1);
    set_dec(OP1_RS1, 1, 0, 1, 0);
    cyc(1, 0, 0, 0, ST_DECODE, OP1_RS1, K_NONE,  32'd1);
    cyc(1, 0, 0, 0, ST_EXEC,   OP1_RS1, K_ALU,   32'd1);
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, ST_MEM,  OP1_RS1, K_DRD,   32'd1);
    cyc(1, 0, 0, 1, ST_MEM,    OP1_RS1, K_DRD,   32'd1);
    cyc(1, 0, 0, 0, ST_WB,     OP1_RS1, K_RF,    32'd1);

    // Store (load and store both flagged) then halt for 5 cycles with a stray imem_ack
    cyc(1, 0, 1, 0, ST_FETCH,  OP1_PC,  K_FETCH, 32'd2);
    set_dec(OP1_PC, 1, 1, 0, 0);
    cyc(1, 0, 0, 0, ST_DECODE, OP1_RS1, K_NONE,  32'd2);
    cyc(1, 0, 0, 0, ST_EXEC,   OP1_PC,  K_ALU,   32'd2);
    cyc(1, 0, 0, 1, ST_MEM,    OP1_RS1, K_DWR,   32'd2);
    for (int i = 0; i < 5; i++)
      cyc(1, 1, 1, 0, ST_FETCH, OP1_PC, K_NONE,  32'd3);
    cyc(1, 0, 0, 0, ST_FETCH,  OP1_PC,  K_IREQ,  32'd3);
    cyc(1, 0, 1, 0, ST_FETCH,  OP1_PC,  K_FETCH, 32'd3);

    // Illegal instruction: one trap pulse, no retire, stray dmem_ack ignored
    set_dec(OP1_ZERO, 1, 0, 1, 1);
    cyc(1, 0, 0, 0, ST_DECODE, OP1_RS1, K_NONE,  32'd3);
    cyc(1, 0, 0, 1, ST_TRAP,   OP1_PC,  K_TRAP,  32'd3);
    cyc(1, 0, 1, 0, ST_FETCH,  OP1_PC,  K_FETCH, 32'd3);

    // Store interrupted by reset in MEM, coincident with dmem_ack
    set_dec(OP1_RS1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, ST_DECODE, OP1_RS1, K_NONE,  32'd3);
    cyc(1, 0, 0, 0, ST_EXEC,   OP1_RS1, K_ALU,   32'd3);
    cyc(1, 0, 0, 0, ST_MEM,    OP1_RS1, K_DWR,   32'd3);
    cyc(0, 0, 0, 1, ST_MEM,    OP1_RS1, K_DWR,   32'd3);
    cyc(0, 0, 0, 0, ST_RST,    OP1_PC,  K_NONE,  32'd0);
    set_dec(OP1_ZERO, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, ST_RST,    OP1_PC,  K_NONE,  32'd0);

    // Counter preloaded to all-ones, one ALU instruction wraps it to zero
    do_force = 1'b1;
    cyc(1, 0, 1, 0, ST_FETCH,  OP1_PC,   K_FETCH, 32'hFFFF_FFFF);
    cyc(1, 0, 0, 0, ST_DECODE, OP1_RS1,  K_NONE,  32'hFFFF_FFFF);
    cyc(1, 0, 0, 0, ST_EXEC,   OP1_ZERO, K_ALU,   32'hFFFF_FFFF);
    cyc(1, 0, 0, 0, ST_WB,     OP1_RS1,  K_RF,    32'hFFFF_FFFF);
    cyc(1, 0, 0, 0, ST_FETCH,  OP1_PC,   K_IREQ,  32'd0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
